// File: rtl/i2c_target_regs.sv
// I2C target register file: NUM_REGS 8-bit registers reachable over an oversampled
// I2C bus (pointer byte then data bytes) and from fabric through a host write port.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h48,
    parameter int         NUM_REGS = 16,
    parameter int         PTR_W    = 4
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    sda_oe,
    input  logic                    host_we,
    input  logic [PTR_W-1:0]        host_addr,
    input  logic [7:0]              host_wdata,
    output logic [8*NUM_REGS-1:0]   regs_flat,
    output logic                    i2c_wr_pulse,
    output logic [PTR_W-1:0]        i2c_wr_addr,
    output logic                    busy
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;

    logic             scl_meta_r, scl_sync_r, scl_hist_r;
    logic             sda_meta_r, sda_sync_r, sda_hist_r;
    logic [3:0]       state_r;
    logic [2:0]       cnt_r;
    logic             phase_r;
    logic             rw_r;
    logic [6:0]       shift_r;
    logic [7:0]       snap_r;
    logic [PTR_W-1:0] ptr_r;
    logic             sda_oe_r;
    logic             busy_r;
    logic             wr_pulse_r;
    logic [PTR_W-1:0] wr_addr_r;
    logic [7:0]       regs_r [NUM_REGS];

    logic       start_s, stop_s, rise_s, fall_s;
    logic [7:0] byte_s;
    logic [7:0] rd_byte_s;

    // Bus line synchronisers plus one history flop; reset to the idle-high bus level
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_hist_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_hist_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_i;
            scl_sync_r <= scl_meta_r;
            scl_hist_r <= scl_sync_r;
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
            sda_hist_r <= sda_sync_r;
        end
    end

    assign start_s   = scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
    assign stop_s    = scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;
    assign rise_s    = scl_sync_r & ~scl_hist_r;
    assign fall_s    = ~scl_sync_r & scl_hist_r;
    assign byte_s    = {shift_r, sda_sync_r};
    assign rd_byte_s = regs_r[ptr_r];

    // Protocol FSM and register array; the I2C write is assigned last so it wins a same-cycle clash
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 3'd0;
            phase_r    <= 1'b0;
            rw_r       <= 1'b0;
            shift_r    <= 7'd0;
            snap_r     <= 8'd0;
            ptr_r      <= '0;
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            wr_pulse_r <= 1'b0;
            wr_addr_r  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 8'd0;
            end
        end else begin
            wr_pulse_r <= 1'b0;
            if (host_we) begin
                regs_r[host_addr] <= host_wdata;
            end
            if (start_s) begin
                state_r  <= ST_ADDR;
                cnt_r    <= 3'd0;
                phase_r  <= 1'b0;
                sda_oe_r <= 1'b0;
            end else if (stop_s) begin
                state_r  <= ST_IDLE;
                sda_oe_r <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sda_oe_r <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (rise_s) begin
                            shift_r <= byte_s[6:0];
                            cnt_r   <= cnt_r + 3'd1;
                            if (cnt_r == 3'd7) begin
                                phase_r <= 1'b0;
                                if (byte_s[7:1] == DEV_ADDR) begin
                                    state_r <= ST_ADDR_ACK;
                                    rw_r    <= byte_s[0];
                                    busy_r  <= 1'b1;
                                end else begin
                                    state_r <= ST_IDLE;
                                end
                            end
                        end
                    end
                    // ACK states: first falling edge drives the ACK, second one ends it
                    ST_ADDR_ACK: begin
                        if (fall_s) begin
                            if (!phase_r) begin
                                sda_oe_r <= 1'b1;
                                phase_r  <= 1'b1;
                            end else begin
                                phase_r <= 1'b0;
                                cnt_r   <= 3'd0;
                                if (rw_r) begin
                                    state_r  <= ST_RDATA;
                                    sda_oe_r <= ~rd_byte_s[7];
                                    snap_r   <= {rd_byte_s[6:0], 1'b0};
                                end else begin
                                    state_r  <= ST_PTR;
                                    sda_oe_r <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_PTR: begin
                        if (rise_s) begin
                            shift_r <= byte_s[6:0];
                            cnt_r   <= cnt_r + 3'd1;
                            if (cnt_r == 3'd7) begin
                                ptr_r   <= byte_s[PTR_W-1:0];
                                phase_r <= 1'b0;
                                state_r <= ST_PTR_ACK;
                            end
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (fall_s) begin
                            if (!phase_r) begin
                                sda_oe_r <= 1'b1;
                                phase_r  <= 1'b1;
                            end else begin
                                phase_r  <= 1'b0;
                                cnt_r    <= 3'd0;
                                sda_oe_r <= 1'b0;
                                state_r  <= ST_WDATA;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (rise_s) begin
                            shift_r <= byte_s[6:0];
                            cnt_r   <= cnt_r + 3'd1;
                            if (cnt_r == 3'd7) begin
                                regs_r[ptr_r] <= byte_s;
                                wr_pulse_r    <= 1'b1;
                                wr_addr_r     <= ptr_r;
                                ptr_r         <= ptr_r + PTR_W'(1);
                                phase_r       <= 1'b0;
                                state_r       <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (fall_s) begin
                            sda_oe_r <= ~snap_r[7];
                            snap_r   <= {snap_r[6:0], 1'b0};
                        end else if (rise_s) begin
                            cnt_r <= cnt_r + 3'd1;
                            if (cnt_r == 3'd7) begin
                                ptr_r   <= ptr_r + PTR_W'(1);
                                phase_r <= 1'b0;
                                state_r <= ST_RDATA_ACK;
                            end
                        end
                    end
                    // phase_r records a master ACK; a NACK ends the read at the rising edge
                    ST_RDATA_ACK: begin
                        if (fall_s) begin
                            if (phase_r) begin
                                state_r  <= ST_RDATA;
                                cnt_r    <= 3'd0;
                                phase_r  <= 1'b0;
                                sda_oe_r <= ~rd_byte_s[7];
                                snap_r   <= {rd_byte_s[6:0], 1'b0};
                            end else begin
                                sda_oe_r <= 1'b0;
                            end
                        end else if (rise_s) begin
                            if (sda_sync_r) begin
                                state_r  <= ST_IDLE;
                                busy_r   <= 1'b0;
                                sda_oe_r <= 1'b0;
                            end else begin
                                phase_r <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        sda_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe       = sda_oe_r;
    assign busy         = busy_r;
    assign i2c_wr_pulse = wr_pulse_r;
    assign i2c_wr_addr  = wr_addr_r;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_r[g];
    end

endmodule
